// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//
// Shared definitions for both sides of the asynchronous FIFO:
//   FIFO_ADDR_WIDTH  default RAM address width (depth = 2**FIFO_ADDR_WIDTH)
//   CODE_W           width of the conversion helpers below
//   bin2gray()       binary -> reflected Gray code
//   gray2bin()       reflected Gray code -> binary
//
// The conversion helpers work on a fixed 32-bit container so that one pair of
// functions serves every pointer width up to 32 bits. Callers zero-extend
// their operand and keep the low bits of the result. This is exact for both
// directions because a zero upper region maps to a zero upper region in
// either code.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int CODE_W          = 32;

    // Adjacent binary values map to Gray values that differ in one bit.
    function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] gray);
        logic [CODE_W-1:0] bin;
        bin[CODE_W-1] = gray[CODE_W-1];
        for (int i = CODE_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
//
// Multi-flop synchronizer for bringing a Gray-coded pointer into another
// clock domain. Only Gray-coded (single-bit-change) buses may pass through
// it, so that any sample is either the old or the new value.
//
// Parameters:
//   WIDTH   bus width
//   STAGES  number of flops in the chain (>= 2)
//
// Ports:
//   clk  in   destination-domain clock
//   rst  in   synchronous active-high reset, clears every stage to 0
//   d    in   WIDTH  bus from the source domain
//   q    out  WIDTH  synchronized bus (output of the last stage)
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/wr_ctrl.sv
// -----------------------------------------------------------------------------
// wr_ctrl
//
// Write-side pointer and flag controller of the asynchronous FIFO, living
// entirely in the write clock domain.
//
// Parameters:
//   ADDR_WIDTH   RAM address width, depth = 2**ADDR_WIDTH (>= 2)
//   SYNC_STAGES  flops in the read-pointer synchronizer (>= 2)
//   AF_THRESH    fill level at or above which almost_full asserts
//
// Ports:
//   wr_clk       in   write-domain clock
//   rst          in   synchronous active-high reset
//   wr_en_sys    in   system write request
//   rd_ptr_gray  in   ADDR_WIDTH+1  Gray extended read pointer (read domain, registered)
//   ram_wen      out  RAM write enable (accepted write)
//   wr_ptr_ram   out  ADDR_WIDTH    RAM write address
//   wr_ptr_gray  out  ADDR_WIDTH+1  registered Gray extended write pointer
//   full         out  registered full flag
//   almost_full  out  registered wr_count >= AF_THRESH
//   wr_count     out  ADDR_WIDTH+1  fill estimate 0..2**ADDR_WIDTH
//   overflow     out  sticky: write requested while full, cleared by rst
//
// Handshake: a write is accepted in a cycle exactly when ram_wen is high;
// wr_en_sys is a request, ~full acts as ready, and nothing is accepted while
// rst is high.
// -----------------------------------------------------------------------------
module wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = (1 << ADDR_WIDTH) - 4
) (
    input  logic                  wr_clk,
    input  logic                  rst,
    input  logic                  wr_en_sys,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  ram_wen,
    output logic [ADDR_WIDTH-1:0] wr_ptr_ram,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  overflow
);

    localparam int AW = ADDR_WIDTH;
    localparam int PW = ADDR_WIDTH + 1;   // extended pointer width (wrap bit on top)

    logic [PW-1:0]     wr_bin;
    logic [PW-1:0]     wr_bin_next;
    logic [PW-1:0]     wr_gray_next;
    logic [PW-1:0]     rd_gray_sync;
    logic [PW-1:0]     rd_bin_sync;
    logic [PW-1:0]     full_match;
    logic [PW-1:0]     count_next;
    logic [CODE_W-1:0] wr_gray_next_w;
    logic [CODE_W-1:0] rd_bin_sync_w;
    logic              unused_hi;

    // ---------------------------------------------------------------------
    // Accept rule. Gating with rst keeps the RAM untouched while the
    // controller is being reset, even if the system keeps requesting.
    // ---------------------------------------------------------------------
    assign ram_wen    = wr_en_sys & ~full & ~rst;
    assign wr_ptr_ram = wr_bin[AW-1:0];

    // Natural PW-bit overflow provides the modulo-2**(AW+1) wrap.
    assign wr_bin_next = wr_bin + {{AW{1'b0}}, ram_wen};

    assign wr_gray_next_w = bin2gray({{(CODE_W-PW){1'b0}}, wr_bin_next});
    assign wr_gray_next   = wr_gray_next_w[PW-1:0];

    // ---------------------------------------------------------------------
    // Read pointer crossing into the write domain.
    // ---------------------------------------------------------------------
    sync_ff #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rd_sync (
        .clk (wr_clk),
        .rst (rst),
        .d   (rd_ptr_gray),
        .q   (rd_gray_sync)
    );

    assign rd_bin_sync_w = gray2bin({{(CODE_W-PW){1'b0}}, rd_gray_sync});
    assign rd_bin_sync   = rd_bin_sync_w[PW-1:0];

    // Upper container bits are always zero; fold them away.
    assign unused_hi = ^{wr_gray_next_w[CODE_W-1:PW], rd_bin_sync_w[CODE_W-1:PW]};

    // In Gray code, "write pointer is exactly one full lap ahead of the read
    // pointer" shows up as the top two bits inverted and the rest equal.
    assign full_match = {~rd_gray_sync[AW:AW-1], rd_gray_sync[AW-2:0]};

    // Occupancy as seen from the write side. Because the read pointer is
    // stale by the synchronizer latency, this only ever over-estimates.
    assign count_next = wr_bin_next - rd_bin_sync;

    // ---------------------------------------------------------------------
    // State. Flags are computed from the post-write pointer so that the
    // write that fills the FIFO raises full on its own edge.
    // ---------------------------------------------------------------------
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            wr_bin      <= '0;
            wr_ptr_gray <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_count    <= '0;
            overflow    <= 1'b0;
        end else begin
            wr_bin      <= wr_bin_next;
            wr_ptr_gray <= wr_gray_next;
            full        <= (wr_gray_next == full_match);
            almost_full <= (int'(count_next) >= AF_THRESH);
            wr_count    <= count_next;
            overflow    <= overflow | (wr_en_sys & full);
        end
    end

endmodule

// File: tb/tb_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wr_ctrl
//
// Bench for wr_ctrl with ADDR_WIDTH=4, SYNC_STAGES=2, AF_THRESH=12.
// The reference model tracks the FIFO as plain integers: total writes
// accepted, the read count presented by the reader, and a short queue that
// delays the read count by the synchronizer latency. Occupancy, flags and
// pointers are derived from those numbers each cycle.
// -----------------------------------------------------------------------------
module tb_wr_ctrl;

    localparam int AW    = 4;
    localparam int PW    = 5;
    localparam int DEPTH = 16;
    localparam int SS    = 2;
    localparam int AF    = 12;
    localparam int EW    = 18;

    // ---------------------------------------------------------------- clock/reset
    logic          wr_clk;
    logic          rst;
    logic          wr_en_sys;
    logic [PW-1:0] rd_ptr_gray;
    logic          ram_wen;
    logic [AW-1:0] wr_ptr_ram;
    logic [PW-1:0] wr_ptr_gray;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] wr_count;
    logic          overflow;

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    wr_ctrl #(
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (SS),
        .AF_THRESH   (AF)
    ) dut (
        .wr_clk      (wr_clk),
        .rst         (rst),
        .wr_en_sys   (wr_en_sys),
        .rd_ptr_gray (rd_ptr_gray),
        .ram_wen     (ram_wen),
        .wr_ptr_ram  (wr_ptr_ram),
        .wr_ptr_gray (wr_ptr_gray),
        .full        (full),
        .almost_full (almost_full),
        .wr_count    (wr_count),
        .overflow    (overflow)
    );

    // ---------------------------------------------------------------- bookkeeping
    int n_checks = 0;
    int n_pass   = 0;

    logic [EW-1:0] exp_q[$];

    // Reference model state
    int m_writes = 0;      // total accepted writes since reset
    int rd_q[$];           // read counts in flight through the synchronizer
    bit m_full   = 0;
    bit m_af     = 0;
    bit m_ovf    = 0;
    int m_count  = 0;
    bit m_valid  = 0;      // model meaningful once a reset edge has been seen
    int rd_cnt   = 0;      // read count currently presented to the DUT

    // Monitor-side observations
    bit            gray_chk     = 0;
    bit            seen_full    = 0;
    int            wen_pulses   = 0;
    logic [PW-1:0] prev_gray;
    bit            prev_gray_ok = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] to_gray(input int n);
        logic [PW-1:0] b;
        b = PW'(n & 31);
        return b ^ (b >> 1);
    endfunction

    // Expected outputs during the cycle with inputs (r, w) applied.
    function automatic logic [EW-1:0] expect_vec(input bit r, input bit w);
        logic          wen;
        logic [AW-1:0] p;
        logic [PW-1:0] g;
        logic [PW-1:0] c;
        wen = w & ~m_full & ~r;
        p   = AW'(m_writes % DEPTH);
        g   = to_gray(m_writes);
        c   = PW'(m_count);
        return {wen, p, g, m_full, m_af, c, m_ovf};
    endfunction

    // ---------------------------------------------------------------- driver
    // Applies one cycle of stimulus, queues the expected outputs for that
    // cycle, then advances the model across the clock edge.
    task automatic cycle(input bit r, input bit w);
        int used;
        bit acc;
        rst         = r;
        wr_en_sys   = w;
        rd_ptr_gray = to_gray(rd_cnt);
        if (m_valid) exp_q.push_back(expect_vec(r, w));
        @(posedge wr_clk);
        if (r) begin
            m_writes = 0;
            rd_q.delete();
            for (int i = 0; i < SS; i++) rd_q.push_back(0);
            m_full  = 0;
            m_af    = 0;
            m_ovf   = 0;
            m_count = 0;
            m_valid = 1;
        end else if (m_valid) begin
            acc      = w && !m_full;
            m_ovf    = m_ovf | (w & m_full);
            m_writes = m_writes + int'(acc);
            used     = rd_q.pop_front();
            rd_q.push_back(rd_cnt);
            m_count  = (m_writes - used) & 31;
            m_full   = (m_count == DEPTH);
            m_af     = (m_count >= AF);
        end
        #1;
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge wr_clk) begin
        logic [EW-1:0] act;
        logic [EW-1:0] e;
        act = {ram_wen, wr_ptr_ram, wr_ptr_gray, full, almost_full, wr_count, overflow};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outputs{wen,ptr,gray,full,af,cnt,ovf}", 32'(act), 32'(e));
        end
        if (ram_wen === 1'b1) wen_pulses++;
        if (gray_chk) begin
            if (full === 1'b1) seen_full = 1;
            if (prev_gray_ok && wr_ptr_gray !== prev_gray)
                check("gray_one_bit", 32'($countones(wr_ptr_gray ^ prev_gray)), 32'd1);
            prev_gray    = wr_ptr_gray;
            prev_gray_ok = 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        rst         = 1'b1;
        wr_en_sys   = 1'b1;
        rd_ptr_gray = '0;

        // Reset held with writes requested
        repeat (3) cycle(1, 1);
        check("rst_ram_wen", 32'(ram_wen), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);

        // Fill from empty
        wen_pulses = 0;
        rd_cnt     = 0;
        repeat (20) cycle(0, 1);
        check("fill_wen_pulses", 32'(wen_pulses), 32'd16);
        check("fill_gray", 32'(wr_ptr_gray), 32'b11000);
        check("fill_count", 32'(wr_count), 32'd16);
        check("fill_full", 32'(full), 32'd1);
        check("fill_af", 32'(almost_full), 32'd1);

        // Keep writing while full, then stop
        repeat (4) cycle(0, 1);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_ptr_held", 32'(wr_ptr_ram), 32'd0);
        repeat (3) cycle(0, 0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reader frees one slot: full drops three edges later
        rd_cnt = 1;
        cycle(0, 0);
        check("drain_full_e1", 32'(full), 32'd1);
        cycle(0, 0);
        check("drain_full_e2", 32'(full), 32'd1);
        cycle(0, 0);
        check("drain_full_e3", 32'(full), 32'd0);
        check("drain_count", 32'(wr_count), 32'd15);
        cycle(0, 1);
        check("refill_gray", 32'(wr_ptr_gray), 32'b11001);
        check("refill_full", 32'(full), 32'd1);

        // Reader catches up one step at a time
        while (rd_cnt < m_writes) begin
            rd_cnt++;
            cycle(0, 0);
        end
        repeat (4) cycle(0, 0);

        // Wrap-around with the reader two cycles behind
        begin
            int wq[$];
            wq.push_back(m_writes);
            wq.push_back(m_writes);
            gray_chk     = 1;
            prev_gray_ok = 0;
            seen_full    = 0;
            repeat (40) begin
                rd_cnt = wq.pop_front();
                wq.push_back(m_writes);
                cycle(0, 1);
            end
            gray_chk = 0;
        end
        check("wrap_never_full", 32'(seen_full), 32'd0);
        check("wrap_ptr", 32'(wr_ptr_ram), 32'd9);
        check("wrap_gray", 32'(wr_ptr_gray), 32'b10101);

        // Random traffic, writer biased to outrun the reader
        repeat (300) begin
            bit w;
            w = ($urandom_range(0, 3) != 0);
            if (rd_cnt < m_writes && $urandom_range(0, 1) == 1) rd_cnt++;
            cycle(0, w);
        end

        // Reset in the middle of a full, overflowed FIFO
        repeat (24) cycle(0, 1);
        check("pre_rst_full", 32'(full), 32'd1);
        check("pre_rst_ovf", 32'(overflow), 32'd1);
        rd_cnt = 0;
        cycle(1, 1);
        check("mid_rst_full", 32'(full), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_count", 32'(wr_count), 32'd0);
        check("mid_rst_gray", 32'(wr_ptr_gray), 32'd0);
        repeat (5) cycle(0, 1);

        wr_en_sys = 1'b0;
        @(negedge wr_clk);
        @(negedge wr_clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
